module_tx_shift_reg_spi: RTL and testbench

MODULE_TX_SHIFT_REG_SPI -- requirements
Module: module_tx_shift_reg_spi

---
 rtl/module_tx_shift_reg_spi_pkg.sv | 7 +
 rtl/module_tx_shift_reg_spi.sv | 44 ++++
 tb/tb_module_tx_shift_reg_spi.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/module_tx_shift_reg_spi_pkg.sv
// Shared SPI constants used across the SPI datapath blocks.
// Holds only values that all SPI blocks agree on.
package module_tx_shift_reg_spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

endpackage

// File: rtl/module_tx_shift_reg_spi.sv
// SPI transmit shift register: parallel load, serial output on data_o.
// The external controller owns bit counting, framing and chip-select.
module module_tx_shift_reg_spi
  import module_tx_shift_reg_spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_en_i,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  data_o
);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] shifted;

  // Zero-fill on the far end so an over-shifted register drains to 0.
  assign shifted = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, shift_q[DATA_WIDTH-1:1]};

  always_comb begin
    shift_d = shift_q;
    if (load_en_i) begin
      shift_d = data_i;
    end else if (shift_en_i) begin
      shift_d = shifted;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign data_o = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];

endmodule

// File: tb/tb_module_tx_shift_reg_spi.sv
// Directed bench for the SPI transmit shift register, MSB-first and
// LSB-first instances sharing one set of inputs.
module tb_module_tx_shift_reg_spi;

  logic       clk_i;
  logic       rst_i;
  logic       load_en_i;
  logic       shift_en_i;
  logic [7:0] data_i;
  logic       data_msb;
  logic       data_lsb;

  int checkCount;
  int passCount;

  module_tx_shift_reg_spi #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_en_i  (load_en_i),
    .shift_en_i (shift_en_i),
    .data_i     (data_i),
    .data_o     (data_msb)
  );

  module_tx_shift_reg_spi #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_en_i  (load_en_i),
    .shift_en_i (shift_en_i),
    .data_i     (data_i),
    .data_o     (data_lsb)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic load, input logic shift, input logic [7:0] data);
    load_en_i  = load;
    shift_en_i = shift;
    data_i     = data;
  endtask

  // Advance to just after the next rising edge so outputs are settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [9:0] msbSeqAA;
  logic [9:0] lsbSeqAA;
  logic [7:0] lsbSeq01;

  initial begin
    checkCount = 0;
    passCount  = 0;
    // Expected data_o per edge: index 0 = after load, index k = after shift k.
    msbSeqAA = 10'b00_0101010_1;
    lsbSeqAA = 10'b00_1010101_0;
    lsbSeq01 = 8'b0000_0001;

    // Reset held with load active: nothing may get through.
    rst_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("reset_msb", data_msb, 0);
      checkOutput("reset_lsb", data_lsb, 0);
      checkOutput("reset_shift_q", dutMsb.shift_q, 0);
    end

    // Load 0xAA then shift ten times.
    applyStimulus(1'b0, 1'b0, 8'h00);
    rst_i = 1'b1;
    tick();
    checkOutput("released_idle", data_msb, 0);
    applyStimulus(1'b1, 1'b0, 8'b1010_1010);
    tick();
    checkOutput("ser_msb_load", data_msb, msbSeqAA[0]);
    checkOutput("ser_lsb_load", data_lsb, lsbSeqAA[0]);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int k = 1; k < 10; k++) begin
      tick();
      checkOutput($sformatf("ser_msb_shift%0d", k), data_msb, msbSeqAA[k]);
      checkOutput($sformatf("ser_lsb_shift%0d", k), data_lsb, lsbSeqAA[k]);
    end

    // Load beats shift on the same edge.
    applyStimulus(1'b1, 1'b0, 8'hA5);
    tick();
    checkOutput("prio_a5_msb", data_msb, 1);
    checkOutput("prio_a5_lsb", data_lsb, 1);
    applyStimulus(1'b1, 1'b1, 8'h3C);
    tick();
    checkOutput("prio_msb", data_msb, 0);
    checkOutput("prio_lsb", data_lsb, 0);
    checkOutput("prio_shift_q", dutMsb.shift_q, 8'h3C);
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("prio_after_shift1", data_msb, 0);
    tick();
    checkOutput("prio_after_shift2", data_msb, 1);

    // Hold with both enables low; data_i changes must be ignored.
    applyStimulus(1'b1, 1'b0, 8'h80);
    tick();
    checkOutput("hold_load80", data_msb, 1);
    applyStimulus(1'b0, 1'b1, 8'h80);
    tick();
    checkOutput("hold_shift80", data_msb, 0);
    applyStimulus(1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_zero", data_msb, 0);
    end
    checkOutput("hold_ignore_data", dutMsb.shift_q, 0);
    applyStimulus(1'b1, 1'b0, 8'hC0);
    tick();
    checkOutput("hold_loadc0", data_msb, 1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("hold_shiftc0", data_msb, 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_one", data_msb, 1);
    end

    // Async reset in the middle of a frame.
    applyStimulus(1'b1, 1'b0, 8'hFF);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("midrst_before", data_msb, 1);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("midrst_msb_async", data_msb, 0);
    checkOutput("midrst_lsb_async", data_lsb, 0);
    #2 rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("midrst_after_msb", data_msb, 0);
      checkOutput("midrst_after_lsb", data_lsb, 0);
    end
    applyStimulus(1'b1, 1'b0, 8'h81);
    tick();
    checkOutput("midrst_reload_msb", data_msb, 1);
    checkOutput("midrst_reload_lsb", data_lsb, 1);

    // LSB-first drain of 0x01; the MSB-first copy reaches its 1 last.
    applyStimulus(1'b1, 1'b0, 8'h01);
    tick();
    checkOutput("lsb01_load", data_lsb, lsbSeq01[0]);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int k = 1; k < 8; k++) begin
      tick();
      checkOutput($sformatf("lsb01_shift%0d", k), data_lsb, lsbSeq01[k]);
    end
    checkOutput("msb01_shift7", data_msb, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
